// File: rtl/sparc_trap_pkg.sv
// rtl/sparc_trap_pkg.sv - shared trap-queue constants, FSM encoding and helpers
//
// Purpose : common definitions for trap_queue and trap_prio_enc.
// Ports   : none (package).
package sparc_trap_pkg;

  localparam int NUM_TRAPS = 6;
  localparam int IDX_W     = 3;

  // Bit 0 of the request/pending vector is the most urgent trap.
  localparam int TRAP_PRIO_HIGHEST = 0;
  localparam int TRAP_PRIO_LOWEST  = NUM_TRAPS - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_STROBE   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  // One-hot mask for a trap index; indices outside the vector give zero.
  function automatic logic [NUM_TRAPS-1:0] bit_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_TRAPS-1:0] m;
    for (int i = 0; i < NUM_TRAPS; i++) begin
      m[i] = (idx == i[IDX_W-1:0]);
    end
    return m;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - lowest-set-bit priority encoder for the trap vector
//
// Purpose : combinational index of the highest-priority (lowest) set bit.
// Ports   : vec   - pending trap vector
//           idx   - index of the lowest set bit (0 when vec is empty)
//           valid - vec has at least one bit set
module trap_prio_enc
  import sparc_trap_pkg::*;
(
  input  logic [NUM_TRAPS-1:0] vec,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan from lowest priority to highest so the last hit wins.
    for (int i = TRAP_PRIO_LOWEST; i >= TRAP_PRIO_HIGHEST; i--) begin
      if (vec[i]) begin
        idx = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/trap_queue.sv
// rtl/trap_queue.sv - pending-trap queue with dispatch strobe sequencer
//
// Purpose : collects trap request pulses, dispatches the highest-priority
//           pending trap to the trap-type encoder and retires it on ack.
// Ports   : clk         - clock, rising edge
//           rst_n       - asynchronous active-low reset
//           trapReq     - one-cycle trap request pulses (bit0 highest priority)
//           et          - enable traps; 0 blocks dispatch, not queuing
//           trapAck     - handler entry, retires the dispatched trap
//           tQout       - registered pending vector for the encoder
//           ttAux       - registered dispatch strobe (encoder samples on rise)
//           trapPending - high from dispatch until retirement
//           dropReq     - pulse when a request hit an already pending/held bit
//           dropCnt     - saturating drop count (only with TRAP_QUEUE_DROP_CNT_EN)
// Config  : TRAP_QUEUE_DROP_CNT_EN adds the dropCnt output and its counter.
module trap_queue
  import sparc_trap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_TRAPS-1:0] trapReq,
  input  logic                 et,
  input  logic                 trapAck,
  output logic [NUM_TRAPS-1:0] tQout,
  output logic                 ttAux,
  output logic                 trapPending,
  output logic                 dropReq
`ifdef TRAP_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]           dropCnt
`endif
);

  state_t               state, next_state;
  logic [NUM_TRAPS-1:0] hold, hold_next;
  logic [NUM_TRAPS-1:0] tq_next;
  logic [IDX_W-1:0]     svc_idx;
  logic [IDX_W-1:0]     low_idx;
  logic                 low_valid;
  logic                 capture;
  logic [NUM_TRAPS-1:0] ack_mask;
  logic                 drop_hit;

  trap_prio_enc u_prio_enc (
    .vec   (tQout),
    .idx   (low_idx),
    .valid (low_valid)
  );

  // The bit being retired this cycle is not "already pending" for a
  // coincident request: that request is a fresh trap, not a duplicate.
  assign ack_mask = (state == ST_WAIT_ACK && trapAck) ? bit_mask(svc_idx) : '0;
  assign drop_hit = |(trapReq & ((tQout & ~ack_mask) | hold));

  always_comb begin
    next_state = state;
    tq_next    = tQout;
    hold_next  = hold;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        tq_next = tQout | trapReq;
        if (low_valid && et) begin
          next_state = ST_SETUP;
          capture    = 1'b1;
        end
      end
      ST_SETUP: begin
        // tQout is frozen while the encoder is being set up and strobed.
        hold_next  = hold | trapReq;
        next_state = ST_STROBE;
      end
      ST_STROBE: begin
        // Requests seen in this last frozen cycle merge directly with hold.
        tq_next    = tQout | hold | trapReq;
        hold_next  = '0;
        next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Request is OR-ed after the clear so a same-bit request wins.
        tq_next = (tQout & ~ack_mask) | trapReq;
        if (trapAck) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tQout       <= '0;
      hold        <= '0;
      svc_idx     <= '0;
      ttAux       <= 1'b0;
      trapPending <= 1'b0;
      dropReq     <= 1'b0;
    end else begin
      state       <= next_state;
      tQout       <= tq_next;
      hold        <= hold_next;
      if (capture) begin
        svc_idx <= low_idx;
      end
      ttAux       <= (next_state == ST_STROBE);
      trapPending <= (next_state != ST_IDLE);
      dropReq     <= drop_hit;
    end
  end

`ifdef TRAP_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt <= '0;
    end else if (dropReq && dropCnt != 8'hFF) begin
      dropCnt <= dropCnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_queue.sv
// tb/tb_trap_queue.sv - self-checking bench for trap_queue
module tb_trap_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] trapReq;
  logic       et;
  logic       trapAck;
  logic [5:0] tQout;
  logic       ttAux;
  logic       trapPending;
  logic       dropReq;
`ifdef TRAP_QUEUE_DROP_CNT_EN
  logic [7:0] dropCnt;
`endif

  always #5 clk = ~clk;

  trap_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trapReq     (trapReq),
    .et          (et),
    .trapAck     (trapAck),
    .tQout       (tQout),
    .ttAux       (ttAux),
    .trapPending (trapPending),
    .dropReq     (dropReq)
`ifdef TRAP_QUEUE_DROP_CNT_EN
    ,
    .dropCnt     (dropCnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: phase 0 idle, 1 setup, 2 strobe, 3 waiting for ack.
  int         m_phase;
  logic [5:0] m_q;
  logic [5:0] m_hold;
  int         m_idx;
  logic       m_drop;
  int         m_cnt;

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_q = '0; m_hold = '0; m_idx = 0; m_drop = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [5:0] req, input logic ack, input logic e);
    logic [5:0] amask;
    logic       new_drop;
    amask = '0;
    if (m_phase == 3 && ack) amask = 6'(1 << m_idx);
    new_drop = |(req & ((m_q & ~amask) | m_hold));
    if (m_drop && m_cnt < 255) m_cnt++;
    case (m_phase)
      0: begin
        if (m_q != 0 && e) begin
          m_idx = lowest(m_q);
          m_phase = 1;
        end
        m_q = m_q | req;
      end
      1: begin m_hold = m_hold | req; m_phase = 2; end
      2: begin m_q = m_q | m_hold | req; m_hold = '0; m_phase = 3; end
      default: begin
        m_q = (m_q & ~amask) | req;
        if (ack) m_phase = 0;
      end
    endcase
    m_drop = new_drop;
  endtask

  task automatic compare_all();
    check("tQout", tQout, m_q);
    check("ttAux", ttAux, m_phase == 2);
    check("trapPending", trapPending, m_phase != 0);
    check("dropReq", dropReq, m_drop);
`ifdef TRAP_QUEUE_DROP_CNT_EN
    check("dropCnt", dropCnt, m_cnt[7:0]);
`endif
  endtask

  task automatic cycle(input logic [5:0] req, input logic ack, input logic e);
    trapReq = req; trapAck = ack; et = e;
    @(posedge clk);
    model_step(req, ack, e);
    #1;
    compare_all();
  endtask

  // Runs idle cycles until the model reaches the ack wait, bounded.
  task automatic to_wait(input logic e);
    int n = 0;
    while (m_phase != 3 && n < 20) begin cycle(6'b0, 1'b0, e); n++; end
    if (m_phase != 3) check("to_wait_timeout", 32'd1, 32'd0);
  endtask

  // Acks every dispatch until the queue is empty, bounded.
  task automatic drain();
    int n = 0;
    while ((m_q != 0 || m_phase != 0) && n < 60) begin
      cycle(6'b0, m_phase == 3, 1'b1); n++;
    end
    if (m_q != 0 || m_phase != 0) check("drain_timeout", 32'd1, 32'd0);
    cycle(6'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; trapReq = '0; et = 1'b1; trapAck = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    check("reset_tQout", tQout, 6'b0);
    rst_n = 1'b1;
    cycle(6'b0, 1'b0, 1'b1);

    // Single request and latency.
    cycle(6'b000100, 1'b0, 1'b1);
    check("single_set", tQout, 6'b000100);
    cycle(6'b0, 1'b0, 1'b1);
    check("single_setup_noaux", ttAux, 1'b0);
    cycle(6'b0, 1'b0, 1'b1);
    check("single_strobe", ttAux, 1'b1);
    cycle(6'b0, 1'b0, 1'b1);
    check("single_wait_aux", ttAux, 1'b0);
    cycle(6'b0, 1'b1, 1'b1);
    check("single_ack_q", tQout, 6'b0);
    check("single_ack_pend", trapPending, 1'b0);
    cycle(6'b0, 1'b0, 1'b1);

    // Priority: bit3 serviced first.
    cycle(6'b101000, 1'b0, 1'b1);
    to_wait(1'b1);
    cycle(6'b0, 1'b1, 1'b1);
    check("prio_first_ack", tQout, 6'b100000);
    to_wait(1'b1);
    cycle(6'b0, 1'b1, 1'b1);
    check("prio_second_ack", tQout, 6'b0);
    cycle(6'b0, 1'b0, 1'b1);

    // Freeze during strobe.
    cycle(6'b010000, 1'b0, 1'b1);
    cycle(6'b0, 1'b0, 1'b1);
    cycle(6'b0, 1'b0, 1'b1);
    check("freeze_strobe_q", tQout, 6'b010000);
    cycle(6'b000001, 1'b0, 1'b1);
    check("freeze_merge_q", tQout, 6'b010001);
    cycle(6'b0, 1'b1, 1'b1);
    check("freeze_ack_q", tQout, 6'b000001);
    drain();

    // et gating.
    cycle(6'b000100, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(6'b0, 1'b0, 1'b0);
    check("et_held", tQout, 6'b000100);
    cycle(6'b0, 1'b0, 1'b1);
    cycle(6'b0, 1'b0, 1'b1);
    check("et_strobe", ttAux, 1'b1);
    cycle(6'b0, 1'b0, 1'b0);
    cycle(6'b0, 1'b1, 1'b0);
    check("et_low_retire", tQout, 6'b0);
    cycle(6'b0, 1'b0, 1'b1);

    // Drop and ack/request collision.
    cycle(6'b000010, 1'b0, 1'b1);
    cycle(6'b000010, 1'b0, 1'b1);
    check("drop_pulse", dropReq, 1'b1);
    cycle(6'b0, 1'b0, 1'b1);
    check("drop_single", dropReq, 1'b0);
`ifdef TRAP_QUEUE_DROP_CNT_EN
    check("drop_cnt", dropCnt, 8'd1);
`endif
    to_wait(1'b1);
    cycle(6'b000010, 1'b1, 1'b1);
    check("collision_q", tQout, 6'b000010);
    check("collision_nodrop", dropReq, 1'b0);
    drain();

    // Reset while waiting for ack.
    cycle(6'b001001, 1'b0, 1'b1);
    to_wait(1'b1);
    cycle(6'b000100, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_q", tQout, 6'b0);
    check("rst_async_pend", trapPending, 1'b0);
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(6'b0, 1'b0, 1'b1);
    check("rst_no_strobe", ttAux, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] r;
      logic       a;
      r = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      a = (m_phase == 3) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      cycle(r, a, $urandom_range(0, 4) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_queue.md
TRAP_QUEUE -- requirements
Module: trap_queue

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port trapReq, input, 6: one-cycle trap request pulses, multi-hot allowed; bit0 is highest priority.
REQ-004 SHALL have port et, input, 1: PSR enable-traps; 0 blocks dispatch but not queuing.
REQ-005 SHALL have port trapAck, input, 1: handler-entry pulse that retires the trap currently dispatched.
REQ-006 SHALL have port tQout, output, 6: registered pending vector that feeds the downstream trap-type encoder.
REQ-007 SHALL have port ttAux, output, 1: registered dispatch strobe; its rising edge is the encoder's sample point.
REQ-008 SHALL have port trapPending, output, 1: high from dispatch until retirement.
REQ-009 SHALL have port dropReq, output, 1: one-cycle pulse when a request hits a bit already pending or held.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, STROBE and WAIT_ACK.
REQ-011 IDLE SHALL move to SETUP when tQout != 0 and et = 1, and otherwise stay in IDLE.
REQ-012 SETUP SHALL move to STROBE after one cycle; ttAux SHALL be 0 in SETUP.
REQ-013 STROBE SHALL hold ttAux = 1 for exactly one cycle, then move to WAIT_ACK.
REQ-014 WAIT_ACK SHALL hold ttAux = 0 and trapPending = 1; on trapAck it SHALL go to IDLE.
REQ-015 On entering SETUP, the FSM SHALL capture svcIdx, the index of the lowest set bit of tQout.
REQ-016 tQout SHALL stay frozen throughout SETUP and STROBE, so the encoder samples a stable vector.
REQ-017 trapReq arriving during SETUP or STROBE SHALL be OR-ed into a 6-bit hold register; the hold register SHALL merge into tQout on the STROBE-to-WAIT_ACK edge and then clear.
REQ-018 In IDLE and WAIT_ACK, trapReq SHALL be OR-ed directly into tQout.
REQ-019 trapAck in WAIT_ACK SHALL clear tQout[svcIdx] only; a trapReq on that same bit in the same cycle SHALL win, leaving the bit set (a new trap).
REQ-020 trapAck outside WAIT_ACK SHALL be ignored.
REQ-021 et falling during SETUP, STROBE or WAIT_ACK SHALL NOT abort the dispatch in progress.
REQ-022 Minimum latency SHALL be 2 cycles: request at edge N gives tQout bit set after N, and the ttAux rise after edge N+2 when in IDLE with et = 1.
REQ-023 Back-to-back traps SHALL re-dispatch via IDLE: at least one IDLE cycle between trapAck and the next SETUP.
REQ-024 dropReq SHALL be asserted in the cycle after a trapReq bit matches an already-set tQout or hold bit; the request SHALL be absorbed with no other effect.

Reset
REQ-025 rst_n low SHALL immediately force state = IDLE, tQout = 0, hold = 0, svcIdx = 0, ttAux = 0, trapPending = 0, dropReq = 0.
REQ-026 Reset mid-dispatch SHALL discard all pending and held traps, with no strobe generated.
REQ-027 Deassertion SHALL take effect at the first clk edge after rst_n rises.

Configuration
REQ-028 Macro TRAP_QUEUE_DROP_CNT_EN SHALL control an extra output dropCnt (8-bit).
REQ-029 With TRAP_QUEUE_DROP_CNT_EN defined, dropCnt SHALL be a saturating count of dropReq pulses, cleared by reset and holding at 255.
REQ-030 With TRAP_QUEUE_DROP_CNT_EN undefined, the dropCnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 A shared package sparc_trap_pkg SHALL hold NUM_TRAPS = 6, the FSM state encoding, and the trap-bit priority constants.
REQ-032 One sub-module, trap_prio_enc, SHALL provide the combinational lowest-set-bit index used to compute svcIdx.

Verification
REQ-033 Single request: trapReq = 6'b000100 with et = 1 -> tQout = 000100; ttAux rises 2 cycles later; trapAck -> tQout = 0 and the FSM returns to IDLE.
REQ-034 Priority: trapReq = 6'b101000, dispatched and acked -> tQout = 100000; a second strobe follows and tQout is 0 after the second ack.
REQ-035 Freeze: trapReq = 000001 injected in STROBE while tQout = 010000 -> tQout stays 010000 through the strobe and becomes 010001 in WAIT_ACK; the ack clears bit4, leaving 000001.
REQ-036 et gating: request with et = 0 -> the bit is held and ttAux stays 0 for 20 cycles; et = 1 -> strobe within 2 cycles.
REQ-037 Drop and collision: repeat trapReq = 000010 while it is pending -> dropReq pulse and dropCnt = 1; trapReq 000010 coincident with its trapAck -> bit stays set.
REQ-038 Reset mid-WAIT_ACK: all outputs are 0 immediately and there is no strobe after release.
